// File: rtl/calc_alu_sequencer.sv
// calc_alu_sequencer
//    Datapath sequencer for the calculator. Hex digits are shifted into
//    operands A and B, the operation code is latched, and on go the
//    sequencer issues a one-cycle start to a multi-cycle ALU. It then waits
//    for done, with a timeout, and holds the captured result and flags for
//    display until the next rst/clr.
//
// Ports
//    clk, rst           clock; asynchronous active-high reset
//    i_clr              synchronous clear, same effect as rst
//    i_digit            hex digit to shift into an operand
//    i_load_a/_b        1-cycle pulses: shift i_digit into A / B
//    i_load_op, i_op_in 1-cycle pulse latching the operation code
//    i_go               1-cycle pulse: execute (only when an op is latched)
//    o_alu_a/_b/_op     operands and op to the ALU (also used by the display)
//    o_alu_start        1-cycle start pulse to the ALU
//    i_alu_done         ALU result valid (1 cycle)
//    i_alu_result/flags ALU result and flags {neg,ovf,carry,zero}
//    o_result/o_flags   captured result and flags
//    o_result_valid     high in DONE
//    o_busy             high in ISSUE or WAIT
//    o_error            high in ERR (timeout)
//    o_cnt_a/_b         number of digits loaded into A / B
//
// state | meaning
// IDLE  | collecting digits and op; go accepted only once an op is latched
// ISSUE | alu_start pulse, timeout timer loaded
// WAIT  | waiting for alu_done, timer running
// DONE  | result/flags captured, held until rst/clr
// ERR   | no done within TIMEOUT cycles, held until rst/clr
module calc_alu_sequencer #(
   parameter int DIGITS  = 4,
   parameter int OPW     = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_clr,
   input  logic [3:0]          i_digit,
   input  logic                i_load_a,
   input  logic                i_load_b,
   input  logic                i_load_op,
   input  logic [OPW-1:0]      i_op_in,
   input  logic                i_go,
   output logic [4*DIGITS-1:0] o_alu_a,
   output logic [4*DIGITS-1:0] o_alu_b,
   output logic [OPW-1:0]      o_alu_op,
   output logic                o_alu_start,
   input  logic                i_alu_done,
   input  logic [4*DIGITS-1:0] i_alu_result,
   input  logic [3:0]          i_alu_flags,
   output logic [4*DIGITS-1:0] o_result,
   output logic [3:0]          o_flags,
   output logic                o_result_valid,
   output logic                o_busy,
   output logic                o_error,
   output logic [2:0]          o_cnt_a,
   output logic [2:0]          o_cnt_b
);

   localparam int W  = 4 * DIGITS;
   localparam int TW = $clog2(TIMEOUT + 1);
   // The timer counts down the WAIT cycles still allowed after the current
   // one; it reaches zero on the TIMEOUT-th WAIT cycle, so ERR is entered
   // exactly TIMEOUT+1 cycles after ISSUE.
   localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);
   localparam logic [2:0]    CNT_MAX    = 3'(DIGITS);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic [OPW-1:0]   r_op;
   logic             r_op_valid;
   logic [2:0]       r_cnt_a;
   logic [2:0]       r_cnt_b;
   logic [TW-1:0]    r_timer;
   logic [W-1:0]     r_result;
   logic [3:0]       r_flags;
   logic             w_timer_tc;

   assign w_timer_tc = (r_timer == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else if (i_clr) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      o_alu_start    = 1'b0;
      o_busy         = 1'b0;
      o_result_valid = 1'b0;
      o_error        = 1'b0;
      case (r_state)
         IDLE: begin
            // r_op_valid is the pre-load value, so a load_op in the same
            // cycle as go does not enable that go.
            if (i_go && r_op_valid) begin
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            o_alu_start = 1'b1;
            o_busy      = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            o_busy = 1'b1;
            // done on the terminal-count cycle still counts as success
            if (i_alu_done) begin
               w_state_nxt = DONE;
            end else if (w_timer_tc) begin
               w_state_nxt = ERR;
            end
         end
         DONE: begin
            o_result_valid = 1'b1;
         end
         ERR: begin
            o_error = 1'b1;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= '0;
         r_op_valid <= 1'b0;
         r_cnt_a    <= '0;
         r_cnt_b    <= '0;
         r_timer    <= '0;
         r_result   <= '0;
         r_flags    <= '0;
      end else if (i_clr) begin
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= '0;
         r_op_valid <= 1'b0;
         r_cnt_a    <= '0;
         r_cnt_b    <= '0;
         r_timer    <= '0;
         r_result   <= '0;
         r_flags    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // load_a has priority; a simultaneous load_b pulse is dropped
               if (i_load_a) begin
                  if (r_cnt_a < CNT_MAX) begin
                     r_a     <= W'({r_a, i_digit});
                     r_cnt_a <= r_cnt_a + 3'd1;
                  end
               end else if (i_load_b) begin
                  if (r_cnt_b < CNT_MAX) begin
                     r_b     <= W'({r_b, i_digit});
                     r_cnt_b <= r_cnt_b + 3'd1;
                  end
               end
               if (i_load_op) begin
                  r_op       <= i_op_in;
                  r_op_valid <= 1'b1;
               end
            end
            ISSUE: begin
               r_timer <= TIMER_LOAD;
            end
            WAIT: begin
               if (i_alu_done) begin
                  r_result <= i_alu_result;
                  r_flags  <= i_alu_flags;
               end else if (!w_timer_tc) begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_alu_a  = r_a;
   assign o_alu_b  = r_b;
   assign o_alu_op = r_op;
   assign o_result = r_result;
   assign o_flags  = r_flags;
   assign o_cnt_a  = r_cnt_a;
   assign o_cnt_b  = r_cnt_b;

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// tb_calc_alu_sequencer
//    Directed bench for calc_alu_sequencer. Each issued operation pushes its
//    expected outcome into a queue; a monitor pops and compares whenever the
//    DUT enters DONE or ERR.
module tb_calc_alu_sequencer;

   localparam int DIGITS  = 4;
   localparam int OPW     = 2;
   localparam int TIMEOUT = 15;
   localparam int W       = 4 * DIGITS;

   logic           clk;
   logic           rst;
   logic           i_clr;
   logic [3:0]     i_digit;
   logic           i_load_a;
   logic           i_load_b;
   logic           i_load_op;
   logic [OPW-1:0] i_op_in;
   logic           i_go;
   logic [W-1:0]   o_alu_a;
   logic [W-1:0]   o_alu_b;
   logic [OPW-1:0] o_alu_op;
   logic           o_alu_start;
   logic           i_alu_done;
   logic [W-1:0]   i_alu_result;
   logic [3:0]     i_alu_flags;
   logic [W-1:0]   o_result;
   logic [3:0]     o_flags;
   logic           o_result_valid;
   logic           o_busy;
   logic           o_error;
   logic [2:0]     o_cnt_a;
   logic [2:0]     o_cnt_b;

   calc_alu_sequencer #(.DIGITS(DIGITS), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_clr          (i_clr),
      .i_digit        (i_digit),
      .i_load_a       (i_load_a),
      .i_load_b       (i_load_b),
      .i_load_op      (i_load_op),
      .i_op_in        (i_op_in),
      .i_go           (i_go),
      .o_alu_a        (o_alu_a),
      .o_alu_b        (o_alu_b),
      .o_alu_op       (o_alu_op),
      .o_alu_start    (o_alu_start),
      .i_alu_done     (i_alu_done),
      .i_alu_result   (i_alu_result),
      .i_alu_flags    (i_alu_flags),
      .o_result       (o_result),
      .o_flags        (o_flags),
      .o_result_valid (o_result_valid),
      .o_busy         (o_busy),
      .o_error        (o_error),
      .o_cnt_a        (o_cnt_a),
      .o_cnt_b        (o_cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         is_err;
      logic [W-1:0] result;
      logic [3:0]   flags;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_a(input logic [3:0] d);
      i_digit = d; i_load_a = 1'b1; step(); i_load_a = 1'b0;
   endtask

   task automatic load_b(input logic [3:0] d);
      i_digit = d; i_load_b = 1'b1; step(); i_load_b = 1'b0;
   endtask

   task automatic load_op(input logic [OPW-1:0] op);
      i_op_in = op; i_load_op = 1'b1; step(); i_load_op = 1'b0;
   endtask

   task automatic clr();
      i_clr = 1'b1; step(); i_clr = 1'b0;
   endtask

   task automatic push(input logic e, input logic [W-1:0] r, input logic [3:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t x;
      x.is_err = e; x.result = r; x.flags = f; x.a = a; x.b = b;
      exp_q.push_back(x);
   endtask

   // Monitor: compare on entry into DONE or ERR
   logic prev_rv  = 1'b0;
   logic prev_err = 1'b0;
   always @(negedge clk) begin
      if ((o_result_valid && !prev_rv) || (o_error && !prev_err)) begin
         if (exp_q.size() == 0) begin
            chk("mon_unexpected_completion", 32'd1, 32'd0);
         end else begin
            exp_t x;
            x = exp_q.pop_front();
            chk("mon_error",  {31'd0, o_error},        {31'd0, x.is_err});
            chk("mon_valid",  {31'd0, o_result_valid}, {31'd0, !x.is_err});
            chk("mon_result", {16'd0, o_result},       {16'd0, x.result});
            chk("mon_flags",  {28'd0, o_flags},        {28'd0, x.flags});
            chk("mon_alu_a",  {16'd0, o_alu_a},        {16'd0, x.a});
            chk("mon_alu_b",  {16'd0, o_alu_b},        {16'd0, x.b});
         end
      end
      prev_rv  <= o_result_valid;
      prev_err <= o_error;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      rst = 1'b1; i_clr = 1'b0; i_digit = '0; i_load_a = 1'b0; i_load_b = 1'b0;
      i_load_op = 1'b0; i_op_in = '0; i_go = 1'b0; i_alu_done = 1'b0;
      i_alu_result = '0; i_alu_flags = '0;
      step(); step();
      rst = 1'b0;
      step();

      // reset state
      chk("rst_alu_a", {16'd0, o_alu_a}, 32'd0);
      chk("rst_flags_state", {27'd0, o_alu_start, o_busy, o_result_valid, o_error, 1'b0}, 32'd0);
      chk("rst_cnts", {26'd0, o_cnt_a, o_cnt_b}, 32'd0);

      // 1: basic operation, done in the 3rd WAIT cycle
      load_a(4'h1); load_a(4'h2); load_a(4'h3); load_a(4'h4);
      load_b(4'h5);
      load_op(2'd2);
      push(1'b0, 16'h1239, 4'b0010, 16'h1234, 16'h0005);
      i_go = 1'b1; step(); i_go = 1'b0;
      chk("t1_start_at_go_plus1", {31'd0, o_alu_start}, 32'd1);
      chk("t1_alu_a", {16'd0, o_alu_a}, 32'h1234);
      chk("t1_alu_b", {16'd0, o_alu_b}, 32'h0005);
      chk("t1_alu_op", {30'd0, o_alu_op}, 32'd2);
      step();
      chk("t1_start_one_cycle", {31'd0, o_alu_start}, 32'd0);
      step(); step();
      i_alu_done = 1'b1; i_alu_result = 16'h1239; i_alu_flags = 4'b0010;
      step();
      i_alu_done = 1'b0; i_alu_result = '0; i_alu_flags = '0;
      chk("t1_result_valid", {31'd0, o_result_valid}, 32'd1);
      chk("t1_result", {16'd0, o_result}, 32'h1239);
      chk("t1_busy_low", {31'd0, o_busy}, 32'd0);
      step();

      // 2: fifth digit ignored
      clr();
      for (int i = 1; i <= 5; i++) load_a(4'(i));
      chk("t2_alu_a", {16'd0, o_alu_a}, 32'h1234);
      chk("t2_cnt_a", {29'd0, o_cnt_a}, 32'd4);

      // 3: go without a latched op, and go together with the first load_op
      clr();
      i_go = 1'b1; step(); i_go = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (o_alu_start || o_busy) bad++;
         step();
      end
      chk("t3_go_no_op_ignored", bad, 32'd0);
      i_op_in = 2'd3; i_load_op = 1'b1; i_go = 1'b1; step();
      i_load_op = 1'b0; i_go = 1'b0;
      chk("t3_go_uses_preload_op_valid", {31'd0, o_alu_start}, 32'd0);
      chk("t3_op_latched", {30'd0, o_alu_op}, 32'd3);

      // 4a: timeout exactly TIMEOUT+1 cycles after ISSUE
      clr();
      load_a(4'hA);
      load_op(2'd1);
      push(1'b1, 16'h0000, 4'b0000, 16'h000A, 16'h0000);
      i_go = 1'b1; step(); i_go = 1'b0;
      chk("t4_issue", {31'd0, o_alu_start}, 32'd1);
      bad = 0;
      for (int k = 1; k <= TIMEOUT; k++) begin
         step();
         if (o_error || !o_busy) bad++;
      end
      chk("t4_no_early_error", bad, 32'd0);
      step();
      chk("t4_error_at_timeout", {31'd0, o_error}, 32'd1);
      chk("t4_result_zero", {16'd0, o_result}, 32'd0);
      step();

      // 4b: done on the TIMEOUT-th WAIT cycle wins
      clr();
      load_op(2'd0);
      push(1'b0, 16'h8001, 4'b1000, 16'h0000, 16'h0000);
      i_go = 1'b1; step(); i_go = 1'b0;
      for (int k = 1; k <= TIMEOUT; k++) step();
      chk("t4b_still_waiting", {30'd0, o_busy, o_error}, 32'd2);
      i_alu_done = 1'b1; i_alu_result = 16'h8001; i_alu_flags = 4'b1000;
      step();
      i_alu_done = 1'b0; i_alu_result = '0; i_alu_flags = '0;
      chk("t4b_done_wins", {30'd0, o_result_valid, o_error}, 32'd2);
      step();

      // 5: clr during WAIT, late done ignored
      clr();
      load_b(4'h9);
      load_op(2'd2);
      i_go = 1'b1; step(); i_go = 1'b0;
      step();
      clr();
      chk("t5_idle_after_clr", {31'd0, o_busy}, 32'd0);
      i_alu_done = 1'b1; i_alu_result = 16'hBEEF; i_alu_flags = 4'hF;
      step();
      i_alu_done = 1'b0; i_alu_result = '0; i_alu_flags = '0;
      step();
      chk("t5_result_valid", {31'd0, o_result_valid}, 32'd0);
      chk("t5_result", {16'd0, o_result}, 32'd0);
      chk("t5_outputs", {o_alu_a, o_alu_b}, 32'd0);

      // 6: simultaneous load_a/load_b, then async reset during ISSUE
      clr();
      i_digit = 4'h7; i_load_a = 1'b1; i_load_b = 1'b1; step();
      i_load_a = 1'b0; i_load_b = 1'b0;
      chk("t6_a", {16'd0, o_alu_a}, 32'h0007);
      chk("t6_b", {16'd0, o_alu_b}, 32'd0);
      chk("t6_cnt_b", {29'd0, o_cnt_b}, 32'd0);
      load_op(2'd1);
      i_go = 1'b1; step(); i_go = 1'b0;
      chk("t6_in_issue", {31'd0, o_alu_start}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_rst_ctrl", {28'd0, o_alu_start, o_busy, o_result_valid, o_error}, 32'd0);
      chk("t6_async_rst_data", {o_alu_a, 13'd0, o_cnt_a}, 32'd0);
      step();
      rst = 1'b0;
      step(); step();

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
